// File: rtl/rv32i_pipe_pkg.sv
// Shared types and constants for the IF/ID pipeline stage.
package rv32i_pipe_pkg;

    localparam int unsigned RV_XLEN = 32;
    localparam int unsigned RV_ILEN = 32;

    // addi x0,x0,0
    localparam logic [RV_ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [RV_XLEN-1:0] pc;
        logic [RV_ILEN-1:0] instr;
    } fetch_beat_t;

endpackage

// File: rtl/if_id_pipe_stage_if.sv
// Valid/ready beat channel carrying a PC and an instruction.
interface if_id_pipe_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ILEN = 32
);
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;

    modport master (output valid, output pc, output instr, input ready);
    modport slave  (input valid, input pc, input instr, output ready);
endinterface

// File: rtl/pipe_entry_reg.sv
// One held fetch beat: enable-loaded PC/instruction register whose clear parks a NOP.
module pipe_entry_reg #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     ILEN      = 32,
    parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(rv32i_pipe_pkg::NOP_INSTR)
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [ILEN-1:0] instr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [ILEN-1:0] instr_o
);

    logic [XLEN-1:0] pc_q;
    logic [ILEN-1:0] instr_q;

    // Clear wins over load and keeps the last PC visible; only the instruction returns to NOP.
    always_ff @(posedge CLK) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else if (clear_i) begin
            instr_q <= NOP_INSTR;
        end else if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_id_pipe_stage.sv
// IF/ID stage: head + optional skid entry, flush handling, registered decode-side outputs.
module if_id_pipe_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     ILEN      = 32,
    parameter int unsigned     PC_SHIFT  = 2,
    parameter bit              SKID_EN   = 1'b1,
    parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(rv32i_pipe_pkg::NOP_INSTR)
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic                      flush,
    output logic                      out_flushed,
    if_id_pipe_stage_if.slave         fetch_if,
    if_id_pipe_stage_if.master        decode_if
);

    import rv32i_pipe_pkg::*;

    stage_state_e    state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            flushed_q;

    logic            in_fire_c, out_fire_c;
    logic            head_load_c, head_clear_c, head_from_skid_c, skid_load_c;
    logic [XLEN-1:0] in_pc_shifted_c, head_pc_d, head_pc, skid_pc;
    logic [ILEN-1:0] head_instr_d, head_instr, skid_instr;

    assign in_pc_shifted_c = XLEN'(fetch_if.pc << PC_SHIFT);

    // With the skid buffer, fetch sees only a register; without it, ready passes decode's ready through.
    assign fetch_if.ready = SKID_EN ? in_ready_q : (!out_valid_q || decode_if.ready);
    assign in_fire_c      = fetch_if.valid && fetch_if.ready;
    assign out_fire_c     = out_valid_q && decode_if.ready;

    // Next-state and entry-control decode; flush clears everything, including a beat offered this cycle.
    always_comb begin
        state_d          = state_q;
        head_load_c      = 1'b0;
        head_clear_c     = 1'b0;
        head_from_skid_c = 1'b0;
        skid_load_c      = 1'b0;
        if (flush) begin
            state_d      = EMPTY;
            head_clear_c = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire_c) begin
                        state_d     = ONE;
                        head_load_c = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire_c && out_fire_c) begin
                        head_load_c = 1'b1;
                    end else if (in_fire_c && SKID_EN) begin
                        state_d     = FULL;
                        skid_load_c = 1'b1;
                    end else if (out_fire_c) begin
                        state_d      = EMPTY;
                        head_clear_c = 1'b1;
                    end
                end
                FULL: begin
                    if (out_fire_c) begin
                        state_d          = ONE;
                        head_load_c      = 1'b1;
                        head_from_skid_c = 1'b1;
                    end
                end
                default: begin
                    state_d      = EMPTY;
                    head_clear_c = 1'b1;
                end
            endcase
        end
        in_ready_d   = (state_d != FULL);
        out_valid_d  = (state_d != EMPTY);
        head_pc_d    = head_from_skid_c ? skid_pc    : in_pc_shifted_c;
        head_instr_d = head_from_skid_c ? skid_instr : fetch_if.instr;
    end

    // Control state, registered ready/valid and the one-cycle flush marker.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            flushed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            flushed_q   <= flush;
        end
    end

    pipe_entry_reg #(.XLEN(XLEN), .ILEN(ILEN), .NOP_INSTR(NOP_INSTR)) u_head (
        .CLK     (CLK),
        .rst     (rst),
        .load_i  (head_load_c),
        .clear_i (head_clear_c),
        .pc_i    (head_pc_d),
        .instr_i (head_instr_d),
        .pc_o    (head_pc),
        .instr_o (head_instr)
    );

    // The skid entry only exists when decoupling is enabled; it is never read out directly.
    if (SKID_EN) begin : g_skid
        pipe_entry_reg #(.XLEN(XLEN), .ILEN(ILEN), .NOP_INSTR(NOP_INSTR)) u_skid (
            .CLK     (CLK),
            .rst     (rst),
            .load_i  (skid_load_c),
            .clear_i (flush),
            .pc_i    (in_pc_shifted_c),
            .instr_i (fetch_if.instr),
            .pc_o    (skid_pc),
            .instr_o (skid_instr)
        );
    end else begin : g_no_skid
        logic unused_skid_load;
        assign unused_skid_load = skid_load_c;
        assign skid_pc          = '0;
        assign skid_instr       = NOP_INSTR;
    end

    assign decode_if.valid = out_valid_q;
    assign decode_if.pc    = head_pc;
    assign decode_if.instr = head_instr;
    assign out_flushed     = flushed_q;

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Bench: default stage (skid, PC<<2) and a single-entry pass-through stage driven by the same stimulus.
module tb_if_id_pipe_stage;

    import rv32i_pipe_pkg::*;

    logic CLK;
    logic rst;
    logic flush;
    logic a_flushed;
    logic b_flushed;

    if_id_pipe_stage_if a_in ();
    if_id_pipe_stage_if a_out ();
    if_id_pipe_stage_if b_in ();
    if_id_pipe_stage_if b_out ();

    if_id_pipe_stage dut_a (
        .CLK         (CLK),
        .rst         (rst),
        .flush       (flush),
        .out_flushed (a_flushed),
        .fetch_if    (a_in),
        .decode_if   (a_out)
    );

    if_id_pipe_stage #(.PC_SHIFT(0), .SKID_EN(1'b0)) dut_b (
        .CLK         (CLK),
        .rst         (rst),
        .flush       (flush),
        .out_flushed (b_flushed),
        .fetch_if    (b_in),
        .decode_if   (b_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: each stage is an ordered queue with a capacity (2 or 1).
    fetch_beat_t  qa[$];
    fetch_beat_t  qb[$];
    bit           fl_a;
    bit           fl_b;
    bit           started;
    logic [31:0]  emitted_a[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int count_emitted(input logic [31:0] pc);
        int n = 0;
        foreach (emitted_a[i]) if (emitted_a[i] == pc) n++;
        return n;
    endfunction

    // One clock: drive at the falling edge, advance the model on the rising edge, check at the next fall.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input logic r);
        bit          a_fire, a_ofire, b_fire, b_ofire, b_rdy;
        logic [31:0] spc;
        rst         = r;
        flush       = fl;
        a_in.valid  = v;
        a_in.pc     = pc;
        a_in.instr  = ins;
        b_in.valid  = v;
        b_in.pc     = pc;
        b_in.instr  = ins;
        a_out.ready = ordy;
        b_out.ready = ordy;
        #1;
        b_rdy = (qb.size() == 0) || ordy;
        if (started) begin
            check("a_in_ready", 64'(a_in.ready), 64'(qa.size() < 2));
            check("b_in_ready", 64'(b_in.ready), 64'(b_rdy));
        end
        a_fire  = v && (qa.size() < 2);
        a_ofire = (qa.size() > 0) && ordy;
        b_fire  = v && b_rdy;
        b_ofire = (qb.size() > 0) && ordy;
        spc     = pc << 2;
        @(posedge CLK);
        if (r) begin
            qa.delete();
            qb.delete();
            fl_a = 1'b0;
            fl_b = 1'b0;
        end else begin
            if (a_ofire) emitted_a.push_back(qa[0].pc);
            fl_a = fl;
            fl_b = fl;
            if (fl) begin
                qa.delete();
                qb.delete();
            end else begin
                if (a_ofire) void'(qa.pop_front());
                if (a_fire) qa.push_back('{pc: spc, instr: ins});
                if (b_ofire) void'(qb.pop_front());
                if (b_fire) qb.push_back('{pc: pc, instr: ins});
            end
        end
        started = 1'b1;
        @(negedge CLK);
        check("a_out_valid", 64'(a_out.valid), 64'(qa.size() > 0));
        if (qa.size() > 0) begin
            check("a_out_pc", 64'(a_out.pc), 64'(qa[0].pc));
            check("a_out_instr", 64'(a_out.instr), 64'(qa[0].instr));
        end else begin
            check("a_out_instr_nop", 64'(a_out.instr), 64'(NOP_INSTR));
        end
        check("a_flushed", 64'(a_flushed), 64'(fl_a));
        check("b_out_valid", 64'(b_out.valid), 64'(qb.size() > 0));
        if (qb.size() > 0) begin
            check("b_out_pc", 64'(b_out.pc), 64'(qb[0].pc));
            check("b_out_instr", 64'(b_out.instr), 64'(qb[0].instr));
        end else begin
            check("b_out_instr_nop", 64'(b_out.instr), 64'(NOP_INSTR));
        end
        check("b_flushed", 64'(b_flushed), 64'(fl_b));
    endtask

    initial begin
        started = 1'b0;
        fl_a    = 1'b0;
        fl_b    = 1'b0;

        // Reset with a beat offered: nothing may be captured.
        step(1'b1, 32'd9, 32'hDEAD_0009, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'd9, 32'hDEAD_0009, 1'b1, 1'b0, 1'b1);
        check("rst_a_pc", 64'(a_out.pc), 64'd0);
        check("rst_a_valid", 64'(a_out.valid), 64'd0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Streaming at full rate.
        for (int i = 0; i < 8; i++)
            step(1'b1, 32'(i), 32'hA000_0000 | 32'(i), 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        check("stream_count", 64'(emitted_a.size()), 64'd8);

        // Backpressure fills head and skid; drain must preserve order.
        emitted_a.delete();
        step(1'b1, 32'd5, 32'hB000_0005, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'd6, 32'hB000_0006, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'd7, 32'hB000_0007, 1'b0, 1'b0, 1'b0);
        check("bp_full_ready", 64'(a_in.ready), 64'd0);
        step(1'b1, 32'd7, 32'hB000_0007, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'd7, 32'hB000_0007, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        check("bp_count", 64'(emitted_a.size()), 64'd3);
        if (emitted_a.size() == 3) begin
            check("bp_order0", 64'(emitted_a[0]), 64'd20);
            check("bp_order1", 64'(emitted_a[1]), 64'd24);
            check("bp_order2", 64'(emitted_a[2]), 64'd28);
        end

        // Flush while FULL with a beat offered.
        emitted_a.delete();
        step(1'b1, 32'd1, 32'hC000_0001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'd2, 32'hC000_0002, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'd3, 32'hC000_0003, 1'b0, 1'b1, 1'b0);
        check("flfull_valid", 64'(a_out.valid), 64'd0);
        check("flfull_flushed", 64'(a_flushed), 64'd1);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        check("flfull_none", 64'(emitted_a.size()), 64'd0);

        // Flush coinciding with out_fire: head counts as consumed, skid is dropped.
        emitted_a.delete();
        step(1'b1, 32'd3, 32'hD000_0003, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'd4, 32'hD000_0004, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        check("flfire_head_once", 64'(count_emitted(32'd12)), 64'd1);
        check("flfire_skid_gone", 64'(count_emitted(32'd16)), 64'd0);

        // Random valid/ready/flush traffic against the queue models.
        for (int i = 0; i < 10000; i++)
            step(1'($urandom_range(99) < 70), $urandom, $urandom,
                 1'($urandom_range(99) < 60), 1'($urandom_range(39) == 0),
                 1'($urandom_range(999) == 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
